// File: rtl/keypad_pkg.sv
// Shared constants and types for the 4x4 keypad scanner and its key decoder.
package keypad_pkg;

  localparam logic [3:0] COL0     = 4'b1110;
  localparam logic [3:0] COL1     = 4'b1101;
  localparam logic [3:0] COL2     = 4'b1011;
  localparam logic [3:0] COL3     = 4'b0111;
  localparam logic [3:0] ROW_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } scan_state_e;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  // Walks the single low strobe bit upward: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  function automatic logic [3:0] next_col(input logic [3:0] col);
    return {col[2:0], col[3]};
  endfunction

endpackage

// File: rtl/keypad_key_map.sv
// Combinational decoder from (column strobe, row return) to the printed hex legend.
module keypad_key_map
  import keypad_pkg::*;
(
  input  logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] code,
  output logic       hit
);

  logic [1:0] row_idx;
  logic       row_hit;
  logic       col_hit;

  // Lowest active-low row index wins when several rows are pulled down.
  always_comb begin
    row_hit = 1'b1;
    row_idx = 2'd0;
    if (!row[0])      row_idx = 2'd0;
    else if (!row[1]) row_idx = 2'd1;
    else if (!row[2]) row_idx = 2'd2;
    else if (!row[3]) row_idx = 2'd3;
    else              row_hit = 1'b0;
  end

  always_comb begin
    col_hit = 1'b1;
    code    = KEY_0;
    case (col)
      COL0: case (row_idx)
              2'd0: code = KEY_A;
              2'd1: code = KEY_B;
              2'd2: code = KEY_C;
              default: code = KEY_D;
            endcase
      COL1: case (row_idx)
              2'd0: code = KEY_3;
              2'd1: code = KEY_6;
              2'd2: code = KEY_9;
              default: code = KEY_F;
            endcase
      COL2: case (row_idx)
              2'd0: code = KEY_2;
              2'd1: code = KEY_5;
              2'd2: code = KEY_8;
              default: code = KEY_0;
            endcase
      COL3: case (row_idx)
              2'd0: code = KEY_1;
              2'd1: code = KEY_4;
              2'd2: code = KEY_7;
              default: code = KEY_E;
            endcase
      default: col_hit = 1'b0;
    endcase
  end

  assign hit = row_hit & col_hit;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column strobing, synchronized row sampling, press/release
// debounce, and single-entry valid/ready delivery of each confirmed key.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_out,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam logic [15:0] TICK_LAST = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  DB_LAST   = 8'(DEBOUNCE_CNT);

  logic [3:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]  db_cnt_q, db_cnt_d;
  logic [3:0]  cand_row_q, cand_row_d;
  logic [3:0]  col_q, col_d;
  scan_state_e state_q, state_d;
  logic        key_valid_q, key_valid_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_held_q, key_held_d;
  logic        overflow_q, overflow_d;

  logic [3:0]  row_s;
  logic        tick;
  logic [7:0]  db_inc;
  logic        confirm;
  logic        drop;
  logic [3:0]  map_code;
  logic        map_hit;

  assign row_s  = sync2_q;
  assign tick   = (tick_cnt_q == TICK_LAST);
  assign db_inc = db_cnt_q + 8'd1;

  keypad_key_map u_key_map (
    .col  (col_q),
    .row  (row_s),
    .code (map_code),
    .hit  (map_hit)
  );

  always_comb begin
    sync1_d     = row_out;
    sync2_d     = sync1_q;
    tick_cnt_d  = tick ? 16'd0 : tick_cnt_q + 16'd1;
    db_cnt_d    = db_cnt_q;
    cand_row_d  = cand_row_q;
    col_d       = col_q;
    state_d     = state_q;
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    overflow_d  = overflow_q;
    confirm     = 1'b0;
    drop        = 1'b0;

    case (state_q)
      SCAN: if (tick) begin
        if (!map_hit) begin
          col_d = next_col(col_q);
        end else begin
          cand_row_d = row_s;
          db_cnt_d   = 8'd1;
          if (DB_LAST == 8'd1) confirm = 1'b1;
          else                 state_d = PRESS_DB;
        end
      end
      PRESS_DB: if (tick) begin
        if (row_s == cand_row_q) begin
          db_cnt_d = db_inc;
          if (db_inc == DB_LAST) confirm = 1'b1;
        end else begin
          state_d = SCAN;
          col_d   = next_col(col_q);
        end
      end
      HELD: if (tick && row_s == ROW_IDLE) begin
        db_cnt_d = 8'd1;
        if (DB_LAST == 8'd1) begin
          key_held_d = 1'b0;
          col_d      = next_col(col_q);
          state_d    = SCAN;
        end else begin
          state_d = REL_DB;
        end
      end
      REL_DB: if (tick) begin
        if (row_s == ROW_IDLE) begin
          db_cnt_d = db_inc;
          if (db_inc == DB_LAST) begin
            key_held_d = 1'b0;
            col_d      = next_col(col_q);
            state_d    = SCAN;
          end
        end else begin
          state_d = HELD;
        end
      end
      default: state_d = SCAN;
    endcase

    if (key_valid_q && key_ready) key_valid_d = 1'b0;

    // A confirmation may reuse the holding register in the same cycle it is drained.
    if (confirm) begin
      state_d    = HELD;
      key_held_d = 1'b1;
      if (!key_valid_q || key_ready) begin
        key_valid_d = 1'b1;
        key_code_d  = map_code;
      end else begin
        drop = 1'b1;
      end
    end

    if (ovf_clr) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= ROW_IDLE;
      sync2_q     <= ROW_IDLE;
      tick_cnt_q  <= 16'd0;
      db_cnt_q    <= 8'd0;
      cand_row_q  <= ROW_IDLE;
      col_q       <= COL0;
      state_q     <= SCAN;
      key_valid_q <= 1'b0;
      key_code_q  <= KEY_0;
      key_held_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      tick_cnt_q  <= tick_cnt_d;
      db_cnt_q    <= db_cnt_d;
      cand_row_q  <= cand_row_d;
      col_q       <= col_d;
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
      overflow_q  <= overflow_d;
    end
  end

  assign col_out   = col_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a table of key presses plus hand-written
// sequences for bounce, overflow, and reset during a held key.
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_out;
  logic [3:0] col_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       key_held;
  logic       overflow;
  logic       ovf_clr;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] code;
  } vec_t;

  vec_t vecs[10];
  logic [3:0] col_seq[4];

  keypad_scan_ctrl #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_out   (row_out),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] row, input logic ready, input logic clr);
    row_out   = row;
    key_ready = ready;
    ovf_clr   = clr;
  endtask

  function automatic logic [3:0] colAfter(input logic [3:0] col);
    logic [3:0] r;
    r = col_seq[0];
    for (int i = 0; i < 4; i++) if (col_seq[i] == col) r = col_seq[(i + 1) % 4];
    return r;
  endfunction

  // Waits until the scan moves onto col, so the row can be applied early in its dwell.
  task automatic waitColEnter(input logic [3:0] col, input string name);
    int n = 0;
    while (col_out == col && n < 60) begin @(negedge clk); n++; end
    while (col_out != col && n < 60) begin @(negedge clk); n++; end
    checkOutput({name, "_col_enter"}, col_out, col);
  endtask

  task automatic waitValid(input int bound, input string name);
    int n = 0;
    while (key_valid !== 1'b1 && n < bound) begin @(negedge clk); n++; end
    checkOutput({name, "_valid_seen"}, 4'(key_valid), 4'h1);
  endtask

  task automatic waitHeld(input logic level, input int bound, input string name);
    int n = 0;
    while (key_held !== level && n < bound) begin @(negedge clk); n++; end
    checkOutput({name, "_held_level"}, 4'(key_held), 4'(level));
  endtask

  task automatic pressKey(input vec_t v, input string name);
    applyStimulus(ROW_IDLE, 1'b1, 1'b0);
    waitColEnter(v.col, name);
    applyStimulus(v.row, 1'b1, 1'b0);
    waitValid(31, name);
    checkOutput({name, "_code"}, key_code, v.code);
    checkOutput({name, "_held"}, 4'(key_held), 4'h1);
    @(negedge clk);
    checkOutput({name, "_valid_pulse"}, 4'(key_valid), 4'h0);
    applyStimulus(ROW_IDLE, 1'b1, 1'b0);
    waitHeld(1'b0, 40, {name, "_release"});
    checkOutput({name, "_col_resume"}, col_out, colAfter(v.col));
  endtask

  task automatic pressHold(input logic [3:0] col, input logic [3:0] row,
                           input logic ready, input logic clr, input string name);
    applyStimulus(ROW_IDLE, ready, clr);
    waitColEnter(col, name);
    applyStimulus(row, ready, clr);
    waitHeld(1'b1, 31, name);
  endtask

  task automatic releaseKey(input logic ready, input logic clr, input string name);
    applyStimulus(ROW_IDLE, ready, clr);
    waitHeld(1'b0, 40, {name, "_release"});
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] prev;
    int         gap;
    bit         saw_valid;
    bit         saw_held;

    col_seq[0] = 4'b1110; col_seq[1] = 4'b1101; col_seq[2] = 4'b1011; col_seq[3] = 4'b0111;

    vecs[0] = '{col: 4'b1101, row: 4'b1110, code: 4'h3};
    vecs[1] = '{col: 4'b1011, row: 4'b1101, code: 4'h5};
    vecs[2] = '{col: 4'b0111, row: 4'b1011, code: 4'h7};
    vecs[3] = '{col: 4'b1110, row: 4'b1010, code: 4'hA};
    vecs[4] = '{col: 4'b1110, row: 4'b0111, code: 4'hD};
    vecs[5] = '{col: 4'b0111, row: 4'b0111, code: 4'hE};
    vecs[6] = '{col: 4'b1011, row: 4'b0111, code: 4'h0};
    vecs[7] = '{col: 4'b1101, row: 4'b0111, code: 4'hF};
    vecs[8] = '{col: 4'b1011, row: 4'b1011, code: 4'h8};
    vecs[9] = '{col: 4'b0111, row: 4'b1110, code: 4'h1};

    rst = 1'b0;
    applyStimulus(ROW_IDLE, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rst_col", col_out, 4'b1110);
    checkOutput("rst_valid", 4'(key_valid), 4'h0);
    checkOutput("rst_code", key_code, 4'h0);
    checkOutput("rst_held", 4'(key_held), 4'h0);
    checkOutput("rst_ovf", 4'(overflow), 4'h0);
    rst = 1'b1;

    // Idle scan: every column change lands 4 clocks after the previous one.
    prev = col_out;
    for (int i = 1; i <= 8; i++) begin
      gap = 0;
      while (col_out == prev && gap < 10) begin @(negedge clk); gap++; end
      checkOutput("idle_col", col_out, col_seq[i % 4]);
      if (i > 1) checkOutput("idle_gap", 4'(gap), 4'd4);
      checkOutput("idle_valid", 4'(key_valid), 4'h0);
      checkOutput("idle_held", 4'(key_held), 4'h0);
      prev = col_out;
    end

    for (int i = 0; i < 10; i++) pressKey(vecs[i], $sformatf("vec%0d", i));

    // Bounce: row alternates every scan tick, so no three agreeing samples occur.
    applyStimulus(ROW_IDLE, 1'b1, 1'b0);
    waitColEnter(4'b0111, "bounce");
    saw_valid = 1'b0;
    saw_held  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus((i % 2 == 0) ? 4'b1011 : ROW_IDLE, 1'b1, 1'b0);
      repeat (4) begin
        @(negedge clk);
        if (key_valid) saw_valid = 1'b1;
        if (key_held)  saw_held  = 1'b1;
      end
    end
    checkOutput("bounce_valid", 4'(saw_valid), 4'h0);
    checkOutput("bounce_held", 4'(saw_held), 4'h0);
    applyStimulus(ROW_IDLE, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    pressKey('{col: 4'b0111, row: 4'b1011, code: 4'h7}, "after_bounce");

    // Consumer stalled: second key is dropped and flagged.
    pressHold(4'b1011, 4'b1101, 1'b0, 1'b0, "stall5");
    checkOutput("stall5_valid", 4'(key_valid), 4'h1);
    checkOutput("stall5_code", key_code, 4'h5);
    releaseKey(1'b0, 1'b0, "stall5");
    pressHold(4'b1011, 4'b1011, 1'b0, 1'b0, "stall8");
    checkOutput("stall8_valid", 4'(key_valid), 4'h1);
    checkOutput("stall8_code", key_code, 4'h5);
    checkOutput("stall8_ovf", 4'(overflow), 4'h1);
    releaseKey(1'b0, 1'b0, "stall8");
    checkOutput("ovf_sticky", 4'(overflow), 4'h1);
    applyStimulus(ROW_IDLE, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("ovf_clr", 4'(overflow), 4'h0);
    checkOutput("ovf_clr_valid", 4'(key_valid), 4'h1);
    applyStimulus(ROW_IDLE, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("drain_valid", 4'(key_valid), 4'h0);

    // A drop coinciding with a held-high ovf_clr still sets overflow.
    pressHold(4'b1101, 4'b1011, 1'b0, 1'b0, "stall9");
    checkOutput("stall9_code", key_code, 4'h9);
    releaseKey(1'b0, 1'b0, "stall9");
    pressHold(4'b1110, 4'b1110, 1'b0, 1'b1, "setwins");
    checkOutput("setwins_ovf", 4'(overflow), 4'h1);
    checkOutput("setwins_code", key_code, 4'h9);
    checkOutput("setwins_valid", 4'(key_valid), 4'h1);
    releaseKey(1'b0, 1'b0, "setwins");
    checkOutput("setwins_ovf_after", 4'(overflow), 4'h1);

    // Reset while a key is held clears the pending key and all flags at once.
    pressHold(4'b1011, 4'b0111, 1'b0, 1'b0, "rsthold");
    checkOutput("rsthold_pre_col", col_out, 4'b1011);
    rst = 1'b0;
    #1;
    checkOutput("rsthold_col", col_out, 4'b1110);
    checkOutput("rsthold_valid", 4'(key_valid), 4'h0);
    checkOutput("rsthold_code", key_code, 4'h0);
    checkOutput("rsthold_held", 4'(key_held), 4'h0);
    checkOutput("rsthold_ovf", 4'(overflow), 4'h0);
    applyStimulus(ROW_IDLE, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    saw_valid = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (key_valid || key_held) saw_valid = 1'b1;
    end
    checkOutput("post_rst_quiet", 4'(saw_valid), 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
